fp_encoder: RTL and testbench



---
 rtl/fpu_pkg.sv | 37 +++
 rtl/fpu_round.sv | 37 +++
 rtl/fp_encoder.sv | 174 +++++++++++++++++
 tb/tb_fp_encoder.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// -----------------------------------------------------------------------------
// fpu_pkg -- constants and types that the FPU datapath blocks share.
//
// Packed float format: {sign, exp[EXP_W-1:0], frac[FRAC_W-1:0]}. The exponent
// is biased by BIAS, and the hidden leading one is not stored in frac.
// Status word layout: {overflow, underflow, inexact, zero}.
// -----------------------------------------------------------------------------
package fpu_pkg;

  localparam int EXP_W     = 10;
  localparam int FRAC_W    = 21;
  localparam int BIAS      = (1 << (EXP_W - 1)) - 1;   // 511
  localparam int EXP_MAX   = (1 << EXP_W) - 1;         // all-ones exponent = infinity
  localparam int MANT_IN_W = 48;
  localparam int IN_EXP_W  = 12;
  localparam int FLOAT_W   = 1 + EXP_W + FRAC_W;       // 32

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } fp_word_t;

  // Bit positions inside the 4-bit status word.
  localparam int STAT_OVF  = 3;
  localparam int STAT_UNF  = 2;
  localparam int STAT_INX  = 1;
  localparam int STAT_ZERO = 0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_NORM  = 2'd1,
    S_ROUND = 2'd2,
    S_PACK  = 2'd3
  } enc_state_t;

endpackage

// File: rtl/fpu_round.sv
// -----------------------------------------------------------------------------
// fpu_round -- combinational rounding step for a normalized significand.
//
// Ports:
//   sig     in  FRAC_W+1  normalized significand including the hidden one
//   guard   in  1         first bit below the lsb
//   sticky  in  1         OR of every bit below guard
//   sum     out FRAC_W+2  sig plus the rounding increment; the top bit is the
//                         carry-out that forces a renormalizing right shift
//   inc     out 1         rounding increment applied
//   inexact out 1         any discarded bit was non-zero
//
// Build option: FP_ENCODER_RNE_EN -- when defined, round-to-nearest-even;
// when undefined, truncate (inc is always 0, inexact still reported).
// -----------------------------------------------------------------------------
module fpu_round
  import fpu_pkg::*;
(
  input  logic [FRAC_W:0]   sig,
  input  logic              guard,
  input  logic              sticky,
  output logic [FRAC_W+1:0] sum,
  output logic              inc,
  output logic              inexact
);

`ifdef FP_ENCODER_RNE_EN
  // Round up above the halfway point, or exactly at it when that makes the lsb even.
  assign inc = guard & (sticky | sig[0]);
`else
  assign inc = 1'b0;
`endif

  assign sum     = {1'b0, sig} + (FRAC_W + 2)'(inc);
  assign inexact = guard | sticky;

endmodule

// File: rtl/fp_encoder.sv
// -----------------------------------------------------------------------------
// fp_encoder -- sequential pack/normalize stage of the FPU.
//
// Takes an unpacked result (sign, unsigned magnitude, signed unbiased exponent,
// value = in_mant * 2^(in_exp - FRAC_W)) and produces a packed 32-bit float
// {sign, exp[9:0], frac[20:0]}. It normalizes one bit per clock, then rounds,
// handles exceptions and packs.
//
// Ports:
//   clock_100Khz in  1          clock
//   reset        in  1          asynchronous, active-low
//   in_valid     in  1          operand valid (ignored unless idle)
//   in_ready     out 1          high only while idle
//   in_sign      in  1          result sign
//   in_mant      in  MANT_IN_W  unsigned magnitude
//   in_exp       in  IN_EXP_W   signed unbiased exponent
//   data_out     out 32         packed float, held until the next result
//   out_valid    out 1          one-cycle pulse when data_out/status_out update
//   status_out   out 4          {overflow, underflow, inexact, zero}
//
// Build option: FP_ENCODER_RNE_EN selects round-to-nearest-even in fpu_round;
// without it the result truncates. Latency is the same either way.
// -----------------------------------------------------------------------------
module fp_encoder
  import fpu_pkg::*;
(
  input  logic                 clock_100Khz,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_sign,
  input  logic [MANT_IN_W-1:0] in_mant,
  input  logic [IN_EXP_W-1:0]  in_exp,
  output logic [FLOAT_W-1:0]   data_out,
  output logic                 out_valid,
  output logic [3:0]           status_out
);

  // Two extra bits so normalization shifts can never wrap the exponent.
  localparam int EW = IN_EXP_W + 2;
  localparam logic signed [EW-1:0] ONE_X   = EW'(1);
  localparam logic signed [EW-1:0] BIAS_X  = EW'(BIAS);
  localparam logic signed [EW-1:0] E_MAX_X = EW'(EXP_MAX);

  enc_state_t              state;
  logic [MANT_IN_W-1:0]    mant;
  logic signed [EW-1:0]    exp_r;
  logic                    sign_r;
  logic                    guard;
  logic                    sticky;
  logic                    inexact;
  logic                    is_zero;

  logic [FRAC_W+1:0]       rnd_sum;
  logic                    rnd_inc;
  logic                    rnd_inexact;

  logic signed [EW-1:0]    exp_biased;
  fp_word_t                pack_word;
  logic [3:0]              pack_status;

  assign in_ready = (state == S_IDLE);

  fpu_round u_round (
    .sig     (mant[FRAC_W:0]),
    .guard   (guard),
    .sticky  (sticky),
    .sum     (rnd_sum),
    .inc     (rnd_inc),
    .inexact (rnd_inexact)
  );

  assign exp_biased = exp_r + BIAS_X;

  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    pack_word      = '0;
    pack_status    = '0;
    pack_word.sign = sign_r;
    // Zero is checked first so a zero operand never reports overflow or
    // underflow because of whatever exponent it arrived with.
    if (is_zero) begin
      pack_status[STAT_ZERO] = 1'b1;
    end else if (exp_biased >= E_MAX_X) begin
      pack_word.exp          = '1;
      pack_status[STAT_OVF]  = 1'b1;
      pack_status[STAT_INX]  = inexact;
    end else if (exp_biased <= 0) begin
      pack_status[STAT_UNF]  = 1'b1;
      pack_status[STAT_INX]  = 1'b1;
    end else begin
      pack_word.exp          = exp_biased[EXP_W-1:0];
      pack_word.frac         = mant[FRAC_W-1:0];
      pack_status[STAT_INX]  = inexact;
    end
  end

  // NOTE: state registers are updated with non-blocking assignments so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock_100Khz or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      mant       <= '0;
      exp_r      <= '0;
      sign_r     <= 1'b0;
      guard      <= 1'b0;
      sticky     <= 1'b0;
      inexact    <= 1'b0;
      is_zero    <= 1'b0;
      data_out   <= '0;
      status_out <= '0;
      out_valid  <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (in_valid) begin
            mant    <= in_mant;
            exp_r   <= {{2{in_exp[IN_EXP_W-1]}}, in_exp};
            sign_r  <= in_sign;
            guard   <= 1'b0;
            sticky  <= 1'b0;
            inexact <= 1'b0;
            is_zero <= 1'b0;
            state   <= S_NORM;
          end
        end

        S_NORM: begin
          if (mant == '0) begin
            is_zero <= 1'b1;
            state   <= S_PACK;
          end else if (|mant[MANT_IN_W-1:FRAC_W+1]) begin
            // Too wide: drop the lsb into guard, fold the old guard into sticky.
            mant   <= mant >> 1;
            exp_r  <= exp_r + ONE_X;
            sticky <= sticky | guard;
            guard  <= mant[0];
          end else if (!mant[FRAC_W]) begin
            // Only reachable with no prior right shift, so guard/sticky are 0
            // and no discarded bits are shifted back in.
            mant  <= mant << 1;
            exp_r <= exp_r - ONE_X;
          end else begin
            state <= S_ROUND;
          end
        end

        S_ROUND: begin
          inexact <= rnd_inexact;
          if (rnd_sum[FRAC_W+1]) begin
            // Increment carried out of 1.111..1; the shifted-out bit is 0.
            mant  <= MANT_IN_W'(rnd_sum >> 1);
            exp_r <= exp_r + ONE_X;
          end else begin
            mant  <= MANT_IN_W'(rnd_sum);
          end
          state <= S_PACK;
        end

        S_PACK: begin
          data_out   <= pack_word;
          status_out <= pack_status;
          out_valid  <= 1'b1;
          state      <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_encoder.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_fp_encoder -- directed self-checking bench for fp_encoder.
// Expected values are hand-computed for format {sign, exp(10, bias 511), frac(21)}.
// -----------------------------------------------------------------------------
module tb_fp_encoder;
  import fpu_pkg::*;

  logic                 clock_100Khz;
  logic                 reset;
  logic                 in_valid;
  logic                 in_ready;
  logic                 in_sign;
  logic [MANT_IN_W-1:0] in_mant;
  logic [IN_EXP_W-1:0]  in_exp;
  logic [31:0]          data_out;
  logic                 out_valid;
  logic [3:0]           status_out;

  int n_checks = 0;
  int n_fail   = 0;

  fp_encoder dut (
    .clock_100Khz (clock_100Khz),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_sign      (in_sign),
    .in_mant      (in_mant),
    .in_exp       (in_exp),
    .data_out     (data_out),
    .out_valid    (out_valid),
    .status_out   (status_out)
  );

  // 100 kHz clock: 10 us period.
  initial clock_100Khz = 1'b0;
  always #5000 clock_100Khz = ~clock_100Khz;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Present one operand, wait (bounded) for out_valid, check result, status
  // and, when exp_lat >= 0, the accept-to-out_valid latency in cycles.
  task automatic run_op(input string tag, input logic s, input logic [MANT_IN_W-1:0] m,
                        input int e, input logic [31:0] exp_data,
                        input logic [3:0] exp_status, input int exp_lat);
    int lat;
    bit seen;
    in_sign  = s;
    in_mant  = m;
    in_exp   = IN_EXP_W'(e);
    in_valid = 1'b1;
    @(posedge clock_100Khz);
    #1;
    in_valid = 1'b0;
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 100) begin
      @(posedge clock_100Khz);
      #1;
      lat++;
      if (out_valid) seen = 1'b1;
    end
    check({tag, " out_valid seen"}, 32'(seen), 32'd1);
    check({tag, " data"}, data_out, exp_data);
    check({tag, " status"}, 32'(status_out), 32'(exp_status));
    if (exp_lat >= 0) check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    @(posedge clock_100Khz);
    #1;
    check({tag, " pulse width"}, 32'(out_valid), 32'd0);
    check({tag, " ready after"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int pulses;
    reset    = 1'b0;
    in_valid = 1'b0;
    in_sign  = 1'b0;
    in_mant  = '0;
    in_exp   = '0;
    repeat (2) @(posedge clock_100Khz);
    #1;
    check("reset data", data_out, 32'h0);
    check("reset status", 32'(status_out), 32'h0);
    check("reset out_valid", 32'(out_valid), 32'h0);
    check("reset in_ready", 32'(in_ready), 32'h1);
    reset = 1'b1;
    @(posedge clock_100Khz);
    #1;

    // Normal values.
    run_op("one",        1'b0, 48'h200000, 0,    32'h3FE00000, 4'b0000, 3);
    run_op("neg_shift",  1'b1, 48'h600000, 0,    32'hC0100000, 4'b0000, 4);
    run_op("tie_even",   1'b0, 48'h400001, 0,    32'h40000000, 4'b0010, 4);
`ifdef FP_ENCODER_RNE_EN
    run_op("tie_up",     1'b0, 48'h400003, 0,    32'h40000002, 4'b0010, 4);
    run_op("rnd_carry",  1'b0, 48'h7FFFFF, 0,    32'h40200000, 4'b0010, 4);
`else
    run_op("tie_up",     1'b0, 48'h400003, 0,    32'h40000001, 4'b0010, 4);
    run_op("rnd_carry",  1'b0, 48'h7FFFFF, 0,    32'h401FFFFF, 4'b0010, 4);
`endif
    // Exceptions.
    run_op("overflow",   1'b0, 48'h200000, 600,  32'h7FE00000, 4'b1000, 3);
    run_op("underflow",  1'b0, 48'h200000, -600, 32'h00000000, 4'b0110, 3);
    run_op("neg_zero",   1'b1, 48'h0,      0,    32'h80000000, 4'b0001, -1);
    // Long left normalization: 21 shifts.
    run_op("left21",     1'b0, 48'h1,      21,   32'h3FE00000, 4'b0000, 24);

    // in_valid while busy must be ignored: exactly one result.
    in_sign  = 1'b0;
    in_mant  = 48'h200000;
    in_exp   = '0;
    in_valid = 1'b1;
    @(posedge clock_100Khz);
    #1;
    check("busy in_ready", 32'(in_ready), 32'd0);
    in_mant  = 48'h600000;
    in_sign  = 1'b1;
    @(posedge clock_100Khz);
    #1;
    in_valid = 1'b0;
    pulses = (out_valid === 1'b1) ? 1 : 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clock_100Khz);
      #1;
      if (out_valid === 1'b1) pulses++;
    end
    check("busy pulses", 32'(pulses), 32'd1);
    check("busy data", data_out, 32'h3FE00000);

    // Reset in the middle of a long normalization.
    in_sign  = 1'b0;
    in_mant  = 48'h1;
    in_exp   = IN_EXP_W'(21);
    in_valid = 1'b1;
    @(posedge clock_100Khz);
    #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clock_100Khz);
    #1;
    reset = 1'b0;
    #1;
    check("midrst data", data_out, 32'h0);
    check("midrst status", 32'(status_out), 32'h0);
    check("midrst out_valid", 32'(out_valid), 32'h0);
    check("midrst in_ready", 32'(in_ready), 32'h1);
    @(negedge clock_100Khz);
    reset = 1'b1;
    @(posedge clock_100Khz);
    #1;
    run_op("after_rst",  1'b0, 48'h200000, 0,    32'h3FE00000, 4'b0000, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
    $finish;
  end

endmodule
